// File: rtl/decod_pkg.sv
// Shared RV32I decode definitions: opcodes, format codes and the decoded record.
package decod_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    TIPO_I = 3'b000,
    TIPO_U = 3'b001,
    TIPO_S = 3'b010,
    TIPO_R = 3'b011,
    TIPO_X = 3'b100,
    TIPO_B = 3'b110,
    TIPO_J = 3'b111
  } tipo_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    tipo_e      tipo;
    logic       illegal;
  } dec_rec_t;

  function automatic tipo_e opcode_tipo(input logic [6:0] op);
    tipo_e t;
    if (op[1:0] != 2'b11) begin
      t = TIPO_X;
    end else begin
      case (op)
        OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_FENCE: t = TIPO_I;
        OP_STORE:                                      t = TIPO_S;
        OP_REG:                                        t = TIPO_R;
        OP_BRANCH:                                     t = TIPO_B;
        OP_LUI, OP_AUIPC:                              t = TIPO_U;
        OP_JAL:                                        t = TIPO_J;
        default:                                       t = TIPO_X;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/decod_comb.sv
// Combinational RV32I decoder: raw instruction to record plus sign-extended immediate.
module decod_comb
  import decod_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output dec_rec_t        rec_o,
  output logic [XLEN-1:0] imm_o
);

  tipo_e              tipo;
  logic signed [31:0] imm32;

  assign tipo = opcode_tipo(instr_i[6:0]);

  always_comb begin
    rec_o        = '0;
    imm32        = '0;
    rec_o.opcode = instr_i[6:0];
    rec_o.tipo   = tipo;
    unique case (tipo)
      TIPO_R: begin
        rec_o.rd     = instr_i[11:7];
        rec_o.rs1    = instr_i[19:15];
        rec_o.rs2    = instr_i[24:20];
        rec_o.funct3 = instr_i[14:12];
        rec_o.funct7 = instr_i[31:25];
      end
      TIPO_I: begin
        rec_o.rd     = instr_i[11:7];
        rec_o.rs1    = instr_i[19:15];
        rec_o.funct3 = instr_i[14:12];
        imm32        = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      TIPO_S: begin
        rec_o.rs1    = instr_i[19:15];
        rec_o.rs2    = instr_i[24:20];
        rec_o.funct3 = instr_i[14:12];
        imm32        = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      TIPO_B: begin
        rec_o.rs1    = instr_i[19:15];
        rec_o.rs2    = instr_i[24:20];
        rec_o.funct3 = instr_i[14:12];
        imm32        = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      end
      TIPO_U: begin
        rec_o.rd = instr_i[11:7];
        imm32    = {instr_i[31:12], 12'b0};
      end
      TIPO_J: begin
        rec_o.rd = instr_i[11:7];
        imm32    = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};
      end
      default: rec_o.illegal = 1'b1;
    endcase
  end

  // Signed cast widens from bit 31 when XLEN is 64.
  assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/decod_stage.sv
// Buffered RV32I decode stage: in-order DEPTH-entry queue of decoded records with flush.
module decod_stage
  import decod_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       opcode,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [XLEN-1:0]  immediate,
  output logic [2:0]       tipo,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  dec_rec_t        dec_rec;
  logic [XLEN-1:0] dec_imm;

  dec_rec_t        rec_mem_q [DEPTH];
  dec_rec_t        rec_mem_d [DEPTH];
  logic [XLEN-1:0] imm_mem_q [DEPTH];
  logic [XLEN-1:0] imm_mem_d [DEPTH];
  logic [XLEN-1:0] pc_mem_q  [DEPTH];
  logic [XLEN-1:0] pc_mem_d  [DEPTH];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]  count_q, count_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  logic push, pop;

  decod_comb #(
    .XLEN(XLEN)
  ) u_decod_comb (
    .instr_i(in_instr),
    .rec_o  (dec_rec),
    .imm_o  (dec_imm)
  );

  assign in_ready  = (count_q < OccW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    rec_mem_d = rec_mem_q;
    imm_mem_d = imm_mem_q;
    pc_mem_d  = pc_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ill_cnt_d = ill_cnt_q;
    if (push) begin
      rec_mem_d[wr_ptr_q] = dec_rec;
      imm_mem_d[wr_ptr_q] = dec_imm;
      pc_mem_d[wr_ptr_q]  = in_pc;
      wr_ptr_d            = wr_ptr_q + PtrW'(1);
      if (dec_rec.illegal && (ill_cnt_q != '1)) begin
        ill_cnt_d = ill_cnt_q + CNT_W'(1);
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + OccW'(1);
      2'b01:   count_d = count_q - OccW'(1);
      default: count_d = count_q;
    endcase
    // Storage is left as-is on flush; out_valid masks the stale head.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        rec_mem_q[i] <= '0;
        imm_mem_q[i] <= '0;
        pc_mem_q[i]  <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ill_cnt_q <= '0;
    end else begin
      rec_mem_q <= rec_mem_d;
      imm_mem_q <= imm_mem_d;
      pc_mem_q  <= pc_mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign out_pc        = pc_mem_q[rd_ptr_q];
  assign immediate     = imm_mem_q[rd_ptr_q];
  assign opcode        = rec_mem_q[rd_ptr_q].opcode;
  assign rd            = rec_mem_q[rd_ptr_q].rd;
  assign rs1           = rec_mem_q[rd_ptr_q].rs1;
  assign rs2           = rec_mem_q[rd_ptr_q].rs2;
  assign funct3        = rec_mem_q[rd_ptr_q].funct3;
  assign funct7        = rec_mem_q[rd_ptr_q].funct7;
  assign tipo          = rec_mem_q[rd_ptr_q].tipo;
  assign illegal       = rec_mem_q[rd_ptr_q].illegal;
  assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_decod_stage.sv
// Directed bench for decod_stage: decode formats, backpressure, saturation, flush, reset.
module tb_decod_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready, out_valid, illegal;
  logic [31:0] out_pc, immediate;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3, tipo;
  logic [2:0]  illegal_count;

  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] out_pc64, immediate64;
  logic [6:0]  opcode64, funct7_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  funct3_64, tipo64;
  logic [2:0]  illegal_count64;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decod_stage #(.XLEN(32), .DEPTH(2), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .immediate(immediate), .tipo(tipo), .illegal(illegal),
    .illegal_count(illegal_count)
  );

  decod_stage #(.XLEN(64), .DEPTH(2), .CNT_W(3)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc({32'b0, in_pc}), .out_valid(out_valid64),
    .out_ready(out_ready), .out_pc(out_pc64), .opcode(opcode64), .rd(rd64),
    .rs1(rs1_64), .rs2(rs2_64), .funct3(funct3_64), .funct7(funct7_64),
    .immediate(immediate64), .tipo(tipo64), .illegal(illegal64),
    .illegal_count(illegal_count64)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    #3;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_pc", out_pc, 0);
    check_eq("rst_imm", immediate, 0);
    check_eq("rst_ill_cnt", illegal_count, 0);
    step();
    rst = 1'b0;
    step();

    // addi x1,x2,-1
    send(32'hFFF1_0093, 32'h100);
    check_eq("addi_valid", out_valid, 1);
    check_eq("addi_tipo", tipo, 3'b000);
    check_eq("addi_rd", rd, 1);
    check_eq("addi_rs1", rs1, 2);
    check_eq("addi_rs2", rs2, 0);
    check_eq("addi_imm", immediate, 32'hFFFF_FFFF);
    check_eq("addi_pc", out_pc, 32'h100);

    // sw x5,8(x2)
    send(32'h0051_2423, 32'h104);
    check_eq("sw_tipo", tipo, 3'b010);
    check_eq("sw_rd", rd, 0);
    check_eq("sw_rs1", rs1, 2);
    check_eq("sw_rs2", rs2, 5);
    check_eq("sw_f3", funct3, 3'b010);
    check_eq("sw_imm", immediate, 32'h0000_0008);

    // lui x3,0x12345
    send(32'h1234_51B7, 32'h108);
    check_eq("lui_tipo", tipo, 3'b001);
    check_eq("lui_rd", rd, 3);
    check_eq("lui_rs1", rs1, 0);
    check_eq("lui_imm", immediate, 32'h1234_5000);

    // beq x0,x0,-4
    send(32'hFE00_0EE3, 32'h10C);
    check_eq("beq_tipo", tipo, 3'b110);
    check_eq("beq_rd", rd, 0);
    check_eq("beq_imm", immediate, 32'hFFFF_FFFC);
    check_eq("beq_imm64", immediate64, 64'hFFFF_FFFF_FFFF_FFFC);

    // sub x3,x1,x2
    send(32'h4020_81B3, 32'h110);
    check_eq("sub_tipo", tipo, 3'b011);
    check_eq("sub_f7", funct7, 7'h20);
    check_eq("sub_rs2", rs2, 2);
    check_eq("sub_imm", immediate, 0);

    // Illegal all-zero word
    send(32'h0000_0000, 32'h114);
    check_eq("ill0_tipo", tipo, 3'b100);
    check_eq("ill0_flag", illegal, 1);
    check_eq("ill0_cnt", illegal_count, 1);
    for (int i = 0; i < 6; i++) send(32'hFFFF_FFFF, 32'h118);
    check_eq("ill_cnt7", illegal_count, 7);
    check_eq("illF_rd", rd, 0);
    check_eq("illF_opcode", opcode, 7'h7F);
    send(32'hFFFF_FFF2, 32'h11C);
    check_eq("ill_sat", illegal_count, 7);
    check_eq("ill_lowbits_tipo", tipo, 3'b100);
    check_eq("ill_lowbits_f3", funct3, 0);
    step();
    check_eq("drain_empty", out_valid, 0);

    // Backpressure with DEPTH=2
    out_ready = 1'b0;
    send(32'hFFF1_0093, 32'h200);
    check_eq("bp_ready_1", in_ready, 1);
    send(32'h0051_2423, 32'h204);
    check_eq("bp_ready_full", in_ready, 0);
    check_eq("bp_head_a", out_pc, 32'h200);
    in_valid = 1'b1; in_instr = 32'h1234_51B7; in_pc = 32'h208;
    step();
    check_eq("bp_hold_pc", out_pc, 32'h200);
    check_eq("bp_hold_imm", immediate, 32'hFFFF_FFFF);
    out_ready = 1'b1;
    step();
    check_eq("bp_head_b", out_pc, 32'h204);
    check_eq("bp_b_tipo", tipo, 3'b010);
    step();
    in_valid = 1'b0;
    check_eq("bp_head_c", out_pc, 32'h208);
    check_eq("bp_c_tipo", tipo, 3'b001);
    step();
    check_eq("bp_empty", out_valid, 0);

    // Flush with two buffered and a concurrent push
    out_ready = 1'b0;
    send(32'hFFF1_0093, 32'h300);
    send(32'h0051_2423, 32'h304);
    in_valid = 1'b1; in_instr = 32'h1234_51B7; in_pc = 32'h308; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("fl_valid", out_valid, 0);
    check_eq("fl_ready", in_ready, 1);
    step();
    check_eq("fl_lost", out_valid, 0);
    check_eq("fl_cnt_kept", illegal_count, 7);

    // Asynchronous reset mid-stream
    send(32'hFFF1_0093, 32'h400);
    check_eq("rs_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rs_valid", out_valid, 0);
    check_eq("rs_pc", out_pc, 0);
    check_eq("rs_rd", rd, 0);
    check_eq("rs_imm", immediate, 0);
    check_eq("rs_cnt", illegal_count, 0);
    check_eq("rs_ready", in_ready, 1);
    step();
    rst = 1'b0;
    step();
    check_eq("rs_after", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
